// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: icodes, status codes, default widths
package pipe_pkg;

    localparam int DEF_WORD_W = 64;
    localparam int DEF_REG_W  = 4;
    localparam int DEF_STAT_W = 2;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [3:0] {
        ICODE_HALT   = 4'h0,
        ICODE_NOP    = 4'h1,
        ICODE_RRMOVQ = 4'h2,
        ICODE_IRMOVQ = 4'h3,
        ICODE_RMMOVQ = 4'h4,
        ICODE_MRMOVQ = 4'h5,
        ICODE_OPQ    = 4'h6,
        ICODE_JXX    = 4'h7,
        ICODE_CALL   = 4'h8,
        ICODE_RET    = 4'h9,
        ICODE_PUSHQ  = 4'hA,
        ICODE_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_BUB = 2'd3
    } stat_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // clear beats a same-cycle increment; the count parks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall, bubble and event statistics
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                WORD_W    = DEF_WORD_W,
    parameter int                REG_W     = DEF_REG_W,
    parameter int                STAT_W    = DEF_STAT_W,
    parameter int                CNT_W     = DEF_CNT_W,
    parameter logic [REG_W-1:0]  BUB_ICODE = REG_W'(ICODE_NOP),
    parameter logic [STAT_W-1:0] BUB_STAT  = STAT_W'(STAT_BUB)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  in_icode,
    input  logic [REG_W-1:0]  in_ifun,
    input  logic [REG_W-1:0]  in_rA,
    input  logic [REG_W-1:0]  in_rB,
    input  logic [WORD_W-1:0] in_valC,
    input  logic [WORD_W-1:0] in_valP,
    input  logic [STAT_W-1:0] in_status,
    input  logic              stall,
    input  logic              bubble,
    input  logic              clr_cnt,
    output logic [REG_W-1:0]  out_icode,
    output logic [REG_W-1:0]  out_ifun,
    output logic [REG_W-1:0]  out_rA,
    output logic [REG_W-1:0]  out_rB,
    output logic [WORD_W-1:0] out_valC,
    output logic [WORD_W-1:0] out_valP,
    output logic [STAT_W-1:0] out_status,
    output logic              out_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              proto_err
);

    logic [REG_W-1:0]  r_icode;
    logic [REG_W-1:0]  r_ifun;
    logic [REG_W-1:0]  r_rA;
    logic [REG_W-1:0]  r_rB;
    logic [WORD_W-1:0] r_valC;
    logic [WORD_W-1:0] r_valP;
    logic [STAT_W-1:0] r_status;
    logic              r_valid;
    logic              r_proto_err;

    logic              w_stall_inc;
    logic              w_bubble_inc;
    logic              w_conflict;

    assign w_stall_inc  = stall & ~bubble;
    assign w_bubble_inc = bubble;
    assign w_conflict   = stall & bubble;

    // reset and bubble both present the nop bubble; stall simply holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_icode  <= BUB_ICODE;
            r_ifun   <= '0;
            r_rA     <= '0;
            r_rB     <= '0;
            r_valC   <= '0;
            r_valP   <= '0;
            r_status <= BUB_STAT;
            r_valid  <= 1'b0;
        end else if (bubble) begin
            r_icode  <= BUB_ICODE;
            r_ifun   <= '0;
            r_rA     <= '0;
            r_rB     <= '0;
            r_valC   <= '0;
            r_valP   <= '0;
            r_status <= BUB_STAT;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_icode  <= in_icode;
            r_ifun   <= in_ifun;
            r_rA     <= in_rA;
            r_rB     <= in_rB;
            r_valC   <= in_valC;
            r_valP   <= in_valP;
            r_status <= in_status;
            r_valid  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (clr_cnt) begin
            r_proto_err <= 1'b0;
        end else if (w_conflict) begin
            r_proto_err <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_bubble_inc),
        .clr   (clr_cnt),
        .count (bubble_cnt)
    );

    assign out_icode  = r_icode;
    assign out_ifun   = r_ifun;
    assign out_rA     = r_rA;
    assign out_rB     = r_rB;
    assign out_valC   = r_valC;
    assign out_valP   = r_valP;
    assign out_status = r_status;
    assign out_valid  = r_valid;
    assign proto_err  = r_proto_err;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WORD_W, default 64, width of valC and valP.
REQ-002 Parameter REG_W, default 4, width of icode, ifun, rA and rB.
REQ-003 Parameter STAT_W, default 2, width of the status field.
REQ-004 Parameter CNT_W, default 16, width of each statistics counter.
REQ-005 Parameter BUB_ICODE, default 4'h1 (nop), icode injected on a bubble.
REQ-006 Parameter BUB_STAT, default 2'd3, status injected on a bubble.
REQ-007 clk  in  1  single clock; all state updates on the rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 in_icode, in_ifun, in_rA, in_rB  in  REG_W each  upstream stage fields.
REQ-010 in_valC, in_valP  in  WORD_W each  upstream constant and next-PC.
REQ-011 in_status  in  STAT_W  upstream status.
REQ-012 stall  in  1  hold the current contents.
REQ-013 bubble  in  1  load the nop bubble.
REQ-014 clr_cnt  in  1  synchronous clear of both counters and proto_err.
REQ-015 out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_status  out  registered copies of the in_* fields, same widths.
REQ-016 out_valid  out  1  contents are a real instruction, not a bubble or reset value.
REQ-017 stall_cnt, bubble_cnt  out  CNT_W  saturating event counters.
REQ-018 proto_err  out  1  sticky flag: stall and bubble were asserted in the same cycle.

Function
REQ-019 Per-cycle priority SHALL be bubble > stall > load.
REQ-020 Bubble: out_icode=BUB_ICODE, out_ifun=0, out_rA=out_rB=0, out_valC=out_valP=0, out_status=BUB_STAT, out_valid=0.
REQ-021 Stall without bubble: every out_* field and out_valid SHALL hold its previous value.
REQ-022 Load (neither asserted): every out_* field SHALL take in_* at the edge, and out_valid=1; latency is exactly one cycle.
REQ-023 In-to-out SHALL have no combinational path; all outputs are flops.
REQ-024 stall_cnt SHALL increment on every cycle with stall=1 and bubble=0.
REQ-025 bubble_cnt SHALL increment on every cycle with bubble=1, stall ignored.
REQ-026 Counters SHALL saturate at all-ones, with no wrap to zero.
REQ-027 proto_err SHALL set on any cycle with stall=1 and bubble=1, and SHALL stay set until clr_cnt or rst.
REQ-028 clr_cnt SHALL zero both counters and proto_err and SHALL win over a same-cycle increment (result 0).
REQ-029 clr_cnt SHALL NOT affect the pipeline fields or out_valid.
REQ-030 Parameter widths SHALL apply uniformly, with no truncation; BUB_* constants are sized to REG_W and STAT_W.

Reset
REQ-031 While rst=1, all outputs SHALL take the bubble values of REQ-020 immediately, without waiting for clk.
REQ-032 While rst=1, stall_cnt=0, bubble_cnt=0 and proto_err=0.
REQ-033 Reset SHALL take effect mid-stall or mid-bubble.
REQ-034 On the first edge after rst falls, normal priority rules SHALL apply.

Structure
REQ-035 A shared package pipe_pkg SHALL hold the icode constants (NOP=1), the status codes (AOK=0, HLT=1, ADR=2, BUB=3) and the default widths.
REQ-036 Each counter SHALL be an instance of one sub-module, sat_counter (CNT_W, inc, clr, async rst).
REQ-037 The fetch-to-decode, decode-to-execute, execute-to-memory and memory-to-writeback registers SHALL all be instances of this block.

Verification
REQ-038 Reset: assert rst between edges -> outputs are icode=1, status=3, valid=0 and counters=0, all before the next clk.
REQ-039 Load: in_icode=6, in_rA=2, in_rB=3, in_valC=64'h10, no stall -> next edge shows the same values, valid=1.
REQ-040 Stall: load icode=3, then hold stall for 3 cycles with in_icode=7 -> out_icode stays 3 and stall_cnt=3.
REQ-041 Bubble and stall together for 1 cycle -> bubble output (icode=1, status=3), bubble_cnt=1, stall_cnt unchanged, proto_err=1 and stays set.
REQ-042 Saturation: CNT_W=4, 20 bubble cycles -> bubble_cnt=15; then clr_cnt with bubble=1 -> bubble_cnt=0.
REQ-043 Reset mid-stall: rst pulses during a stall -> fields go to bubble values at once; the first load after release passes through normally.
